ws2812_write_arbiter: RTL and testbench

- Shares the single write port of the ws2812 LED driver (rgb_data / led_num / write) between two requesters, e.g. host command decoder and pattern engine.
- Round-robin arbitration with valid/ready handshakes per requester.
- Sequences "fill" commands that write one colour to every LED over consecutive cycles.
- Sits directly upstream of the ws2812 instance; outputs are registered and connect straight to its write inputs.

---
 rtl/ws2812_pkg.sv | 12 +
 rtl/ws2812_write_arbiter_if.sv | 41 ++++
 rtl/ws2812_write_arbiter_rr_arbiter2.sv | 36 +++
 rtl/ws2812_write_arbiter.sv | 127 ++++++++++++
 tb/tb_ws2812_write_arbiter.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for blocks that drive the ws2812 LED write port.
package ws2812_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_e;

  localparam int RGB_W         = 24;
  localparam int DEF_LED_NUM_W = 8;

endpackage

// File: rtl/ws2812_write_arbiter_if.sv
// Requester handshakes plus the registered write port towards the ws2812 driver.
interface ws2812_write_arbiter_if
  import ws2812_pkg::*;
#(
  parameter int LED_NUM_W = DEF_LED_NUM_W
);

  logic                 req0_valid;
  logic                 req0_ready;
  logic                 req0_fill;
  logic [LED_NUM_W-1:0] req0_led_num;
  logic [RGB_W-1:0]     req0_rgb;

  logic                 req1_valid;
  logic                 req1_ready;
  logic                 req1_fill;
  logic [LED_NUM_W-1:0] req1_led_num;
  logic [RGB_W-1:0]     req1_rgb;

  logic                 wr_write;
  logic [LED_NUM_W-1:0] wr_led_num;
  logic [RGB_W-1:0]     wr_rgb_data;
  logic                 grant_id;
  logic                 busy;
  logic                 drop;

  modport master (
    output req0_valid, req0_fill, req0_led_num, req0_rgb,
    output req1_valid, req1_fill, req1_led_num, req1_rgb,
    input  req0_ready, req1_ready,
    input  wr_write, wr_led_num, wr_rgb_data, grant_id, busy, drop
  );

  modport slave (
    input  req0_valid, req0_fill, req0_led_num, req0_rgb,
    input  req1_valid, req1_fill, req1_led_num, req1_rgb,
    output req0_ready, req1_ready,
    output wr_write, wr_led_num, wr_rgb_data, grant_id, busy, drop
  );

endinterface

// File: rtl/ws2812_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer moves to the other requester only on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant,
  output logic       grant_idx
);

  logic ptr_q, ptr_d;
  logic pick;
  logic accept;

  always_comb begin
    pick = ptr_q;
    if (valid == 2'b01) begin
      pick = 1'b0;
    end else if (valid == 2'b10) begin
      pick = 1'b1;
    end
    accept    = en && (valid != 2'b00);
    grant     = {pick, ~pick} & {2{accept}};
    grant_idx = pick;
    ptr_d     = accept ? ~pick : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ws2812_write_arbiter.sv
// Shares the ws2812 write port between two requesters; single writes pass through
// with one cycle of latency, fill commands sweep one colour across every LED.
module ws2812_write_arbiter
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = 8,
  parameter int LED_NUM_W = DEF_LED_NUM_W
) (
  input  logic                   clk,
  input  logic                   reset,
  ws2812_write_arbiter_if.slave  bus
);

  localparam int                   CNT_W     = $clog2(NUM_LEDS) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(NUM_LEDS - 1);
  localparam logic [LED_NUM_W:0]   LED_LIMIT = (LED_NUM_W + 1)'(NUM_LEDS);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [RGB_W-1:0]     fill_rgb_q, fill_rgb_d;
  logic                 wr_write_q, wr_write_d;
  logic [LED_NUM_W-1:0] wr_led_num_q, wr_led_num_d;
  logic [RGB_W-1:0]     wr_rgb_q, wr_rgb_d;
  logic                 grant_id_q, grant_id_d;
  logic                 drop_q, drop_d;

  logic [1:0]           grant;
  logic                 gnt_idx;
  logic                 accept;
  logic                 sel_fill;
  logic [LED_NUM_W-1:0] sel_led;
  logic [RGB_W-1:0]     sel_rgb;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (reset),
    .en        (state_q == ST_IDLE),
    .valid     ({bus.req1_valid, bus.req0_valid}),
    .grant     (grant),
    .grant_idx (gnt_idx)
  );

  assign accept   = |grant;
  assign sel_fill = gnt_idx ? bus.req1_fill    : bus.req0_fill;
  assign sel_led  = gnt_idx ? bus.req1_led_num : bus.req0_led_num;
  assign sel_rgb  = gnt_idx ? bus.req1_rgb     : bus.req0_rgb;
  assign cnt_nxt  = cnt_q + CNT_W'(1);

  // cnt_q tracks the LED index currently presented on the write port during a fill,
  // so index 0 is issued straight from the accept and busy spans exactly NUM_LEDS cycles.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_rgb_d   = fill_rgb_q;
    wr_write_d   = 1'b0;
    wr_led_num_d = wr_led_num_q;
    wr_rgb_d     = wr_rgb_q;
    grant_id_d   = grant_id_q;
    drop_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grant_id_d = gnt_idx;
          if (sel_fill) begin
            state_d      = ST_FILL;
            fill_rgb_d   = sel_rgb;
            cnt_d        = '0;
            wr_write_d   = 1'b1;
            wr_led_num_d = '0;
            wr_rgb_d     = sel_rgb;
          end else if ({1'b0, sel_led} < LED_LIMIT) begin
            wr_write_d   = 1'b1;
            wr_led_num_d = sel_led;
            wr_rgb_d     = sel_rgb;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d        = cnt_nxt;
          wr_write_d   = 1'b1;
          wr_led_num_d = LED_NUM_W'(cnt_nxt);
          wr_rgb_d     = fill_rgb_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      fill_rgb_q   <= '0;
      wr_write_q   <= 1'b0;
      wr_led_num_q <= '0;
      wr_rgb_q     <= '0;
      grant_id_q   <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fill_rgb_q   <= fill_rgb_d;
      wr_write_q   <= wr_write_d;
      wr_led_num_q <= wr_led_num_d;
      wr_rgb_q     <= wr_rgb_d;
      grant_id_q   <= grant_id_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.req0_ready  = grant[0];
  assign bus.req1_ready  = grant[1];
  assign bus.wr_write    = wr_write_q;
  assign bus.wr_led_num  = wr_led_num_q;
  assign bus.wr_rgb_data = wr_rgb_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.busy        = (state_q == ST_FILL);
  assign bus.drop        = drop_q;

endmodule

// File: tb/tb_ws2812_write_arbiter.sv
// Directed vector bench for ws2812_write_arbiter with NUM_LEDS = 8.
module tb_ws2812_write_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ws2812_write_arbiter_if #(.LED_NUM_W(8)) bus ();

  ws2812_write_arbiter #(.NUM_LEDS(8), .LED_NUM_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v0, f0;
    logic [7:0]  l0;
    logic [23:0] c0;
    logic        v1, f1;
    logic [7:0]  l1;
    logic [23:0] c1;
    logic        r0, r1, wr;
    logic [7:0]  led;
    logic [23:0] rgb;
    logic        gid, busy, drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic v0, input logic f0, input logic [7:0] l0, input logic [23:0] c0,
    input logic v1, input logic f1, input logic [7:0] l1, input logic [23:0] c1,
    input logic r0, input logic r1,
    input logic wr, input logic [7:0] led, input logic [23:0] rgb,
    input logic gid, input logic busy, input logic drop);
    vec_t v;
    v.v0 = v0; v.f0 = f0; v.l0 = l0; v.c0 = c0;
    v.v1 = v1; v.f1 = f1; v.l1 = l1; v.c1 = c1;
    v.r0 = r0; v.r1 = r1; v.wr = wr; v.led = led; v.rgb = rgb;
    v.gid = gid; v.busy = busy; v.drop = drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic f0, input logic [7:0] l0, input logic [23:0] c0,
                       input logic v1, input logic f1, input logic [7:0] l1, input logic [23:0] c1);
    bus.req0_valid = v0; bus.req0_fill = f0; bus.req0_led_num = l0; bus.req0_rgb = c0;
    bus.req1_valid = v1; bus.req1_fill = f1; bus.req1_led_num = l1; bus.req1_rgb = c1;
  endtask

  initial begin
    bit hit;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 0, 8'd0, 24'h0, 0, 0, 8'd0, 24'h0);

    // Each row: inputs for this cycle, ready expected this cycle, outputs registered from the previous row.
    vecs.push_back(mk(0,0,8'd0,24'h0,      0,0,8'd0,24'h0,      0,0, 0,8'd0,24'h0,      0,0,0));
    vecs.push_back(mk(1,0,8'd3,24'h00FF00, 0,0,8'd0,24'h0,      1,0, 0,8'd0,24'h0,      0,0,0));
    vecs.push_back(mk(0,0,8'd0,24'h0,      0,0,8'd0,24'h0,      0,0, 1,8'd3,24'h00FF00, 0,0,0));
    vecs.push_back(mk(1,0,8'd1,24'hAAAAAA, 1,0,8'd2,24'hBBBBBB, 0,1, 0,8'd3,24'h00FF00, 0,0,0));
    vecs.push_back(mk(1,0,8'd1,24'hAAAAAA, 1,0,8'd2,24'hBBBBBB, 1,0, 1,8'd2,24'hBBBBBB, 1,0,0));
    vecs.push_back(mk(1,0,8'd1,24'hAAAAAA, 1,0,8'd2,24'hBBBBBB, 0,1, 1,8'd1,24'hAAAAAA, 0,0,0));
    vecs.push_back(mk(1,0,8'd1,24'hAAAAAA, 1,0,8'd2,24'hBBBBBB, 1,0, 1,8'd2,24'hBBBBBB, 1,0,0));
    vecs.push_back(mk(0,0,8'd0,24'h0,      0,0,8'd0,24'h0,      0,0, 1,8'd1,24'hAAAAAA, 0,0,0));
    vecs.push_back(mk(1,0,8'd5,24'h0000FF, 0,0,8'd0,24'h0,      1,0, 0,8'd1,24'hAAAAAA, 0,0,0));
    vecs.push_back(mk(0,0,8'd0,24'h0,      0,0,8'd0,24'h0,      0,0, 1,8'd5,24'h0000FF, 0,0,0));
    vecs.push_back(mk(0,0,8'd0,24'h0,      1,0,8'd8,24'h111111, 0,1, 0,8'd5,24'h0000FF, 0,0,0));
    vecs.push_back(mk(0,0,8'd0,24'h0,      0,0,8'd0,24'h0,      0,0, 0,8'd5,24'h0000FF, 1,0,1));
    vecs.push_back(mk(0,0,8'd0,24'h0,      0,0,8'd0,24'h0,      0,0, 0,8'd5,24'h0000FF, 1,0,0));
    vecs.push_back(mk(0,0,8'd0,24'h0,      1,1,8'd0,24'h123456, 0,1, 0,8'd5,24'h0000FF, 1,0,0));
    for (int k = 0; k < 8; k++) begin
      vecs.push_back(mk(1,0,8'd7,24'hCCCCCC, 0,0,8'd0,24'h0, 0,0, 1,8'(k),24'h123456, 1,1,0));
    end
    vecs.push_back(mk(1,0,8'd7,24'hCCCCCC, 0,0,8'd0,24'h0,      1,0, 0,8'd7,24'h123456, 1,0,0));
    vecs.push_back(mk(0,0,8'd0,24'h0,      0,0,8'd0,24'h0,      0,0, 1,8'd7,24'hCCCCCC, 0,0,0));

    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].f0, vecs[i].l0, vecs[i].c0,
            vecs[i].v1, vecs[i].f1, vecs[i].l1, vecs[i].c1);
      #1;
      check($sformatf("row%0d req0_ready", i),  bus.req0_ready,  vecs[i].r0);
      check($sformatf("row%0d req1_ready", i),  bus.req1_ready,  vecs[i].r1);
      check($sformatf("row%0d wr_write", i),    bus.wr_write,    vecs[i].wr);
      check($sformatf("row%0d wr_led_num", i),  bus.wr_led_num,  vecs[i].led);
      check($sformatf("row%0d wr_rgb_data", i), bus.wr_rgb_data, vecs[i].rgb);
      check($sformatf("row%0d grant_id", i),    bus.grant_id,    vecs[i].gid);
      check($sformatf("row%0d busy", i),        bus.busy,        vecs[i].busy);
      check($sformatf("row%0d drop", i),        bus.drop,        vecs[i].drop);
    end

    // Reset in the middle of a fill, then the pointer must favour req0 again.
    @(negedge clk);
    drive(0, 0, 8'd0, 24'h0, 1, 1, 8'd0, 24'h654321);
    #1;
    check("abort fill accept", bus.req1_ready, 1'b1);
    @(negedge clk);
    drive(0, 0, 8'd0, 24'h0, 0, 0, 8'd0, 24'h0);
    hit = 1'b0;
    for (int n = 0; n < 20 && !hit; n++) begin
      #1;
      if (bus.wr_write && bus.wr_led_num == 8'd4) hit = 1'b1;
      else @(negedge clk);
    end
    check("abort reach index4", hit, 1'b1);
    check("abort fill rgb", bus.wr_rgb_data, 24'h654321);
    reset = 1'b1;
    #1;
    check("abort wr_write", bus.wr_write, 1'b0);
    check("abort busy", bus.busy, 1'b0);
    check("abort wr_led_num", bus.wr_led_num, 8'd0);
    check("abort wr_rgb_data", bus.wr_rgb_data, 24'h0);
    #1;
    reset = 1'b0;

    @(negedge clk);
    drive(1, 0, 8'd6, 24'hDDDDDD, 1, 0, 8'd2, 24'hEEEEEE);
    #1;
    check("post reset req0_ready", bus.req0_ready, 1'b1);
    check("post reset req1_ready", bus.req1_ready, 1'b0);
    @(negedge clk);
    drive(0, 0, 8'd0, 24'h0, 0, 0, 8'd0, 24'h0);
    #1;
    check("post reset wr_write", bus.wr_write, 1'b1);
    check("post reset wr_led_num", bus.wr_led_num, 8'd6);
    check("post reset wr_rgb_data", bus.wr_rgb_data, 24'hDDDDDD);
    check("post reset grant_id", bus.grant_id, 1'b0);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      #1;
      check($sformatf("quiet%0d wr_write", n), bus.wr_write, 1'b0);
      check($sformatf("quiet%0d busy", n), bus.busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
